// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types and default sizing for the sequential multiplier.
package seq_mult_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int N_DEF  = 8;             // default operand width
   localparam int PW_DEF = 2 * N_DEF;     // default product width
   localparam int CW_DEF = $clog2(N_DEF); // iteration counter width

endpackage

// File: rtl/seq_mult_8x8_if.sv
// seq_mult_8x8_if: operand/product handshake bundle for the sequential multiplier.
interface seq_mult_8x8_if #(parameter int N = seq_mult_pkg::N_DEF);

   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             out_valid;
   logic             out_ready;
   logic [2*N-1:0]   product;
   logic             busy;

   // producer/consumer side
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   // multiplier side
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );

endinterface

// File: rtl/mult_add_stage.sv
// mult_add_stage: combinational W-bit ripple adder built from half/full adder cells.
module mult_ha (
   output logic s,
   output logic co,
   input  logic x,
   input  logic y
);
   assign s  = x ^ y;
   assign co = x & y;
endmodule

module mult_fa (
   output logic s,
   output logic co,
   input  logic x,
   input  logic y,
   input  logic ci
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

module mult_add_stage #(parameter int W = seq_mult_pkg::PW_DEF) (
   output logic [W-1:0] sum,
   output logic         carry,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y
);
   // c[i] is the carry into bit i
   logic [W:1] c;

   mult_ha u_ha0 (.s(sum[0]), .co(c[1]), .x(x[0]), .y(y[0]));

   genvar i;
   generate
      for (i = 1; i < W; i++) begin : g_bit
         mult_fa u_fa (.s(sum[i]), .co(c[i+1]), .x(x[i]), .y(y[i]), .ci(c[i]));
      end
   endgenerate

   assign carry = c[W];
endmodule

// File: rtl/seq_mult_8x8.sv
// seq_mult_8x8: shift-and-add unsigned N x N multiplier, one operation in flight.
// Optional macro MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module seq_mult_8x8
   import seq_mult_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic clk,
   input  logic rst,
   seq_mult_8x8_if.slave bus
);
   localparam int PW = 2 * N;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t          state;
   logic [PW-1:0]   acc;
   logic [PW-1:0]   mcand;
   logic [N-1:0]    mplier;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   add_sum;
   logic [PW-1:0]   acc_nxt;
   logic            last;

   // partial product accumulate; an N x N product never carries out of 2N bits
   mult_add_stage #(.W(PW)) u_add (
      .sum   (add_sum),
      .carry (),
      .x     (acc),
      .y     (mcand)
   );

   // next accumulator value and final-iteration detect
   always_comb begin
      acc_nxt = mplier[0] ? add_sum : acc;
`ifdef MULT_EARLY_EXIT_EN
      last    = ((mplier >> 1) == '0) || (cnt == CW'(N - 1));
`else
      last    = (cnt == CW'(N - 1));
`endif
   end

   // control FSM and datapath registers, all outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         acc           <= '0;
         mcand         <= '0;
         mplier        <= '0;
         cnt           <= '0;
         bus.product   <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mcand        <= {{N{1'b0}}, bus.a};
                  mplier       <= bus.b;
                  acc          <= '0;
                  cnt          <= '0;
                  state        <= BUSY;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
               end
            end
            BUSY: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  state         <= DONE;
                  bus.product   <= acc_nxt;
                  bus.busy      <= 1'b0;
                  bus.out_valid <= 1'b1;
               end
            end
            DONE: begin
               // new operands wait for the IDLE cycle that follows
               if (bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_8x8.sv
// tb_seq_mult_8x8: scoreboard bench for seq_mult_8x8 (products, latency, handshake, reset).
module tb_seq_mult_8x8;
   import seq_mult_pkg::*;

   localparam int N = 8;

   typedef struct {
      logic [2*N-1:0] prod;
      int             acc_cyc;
      int             lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   logic ov_q = 1'b0;

   seq_mult_8x8_if #(.N(N)) bus ();

   seq_mult_8x8 #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int exp_lat(input logic [N-1:0] b);
      int l;
      l = N;
`ifdef MULT_EARLY_EXIT_EN
      l = 1;
      for (int i = 0; i < N; i++) if (b[i]) l = i + 1;
`endif
      return l;
   endfunction

   // compare each product when out_valid rises
   always @(negedge clk) begin
      if (bus.out_valid && !ov_q) begin
         if (exp_q.size() == 0) begin
            chk("q_empty", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("product", 32'(bus.product), 32'(e.prod));
            chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
         end
      end
      ov_q <= bus.out_valid;
   end

   // called at a negedge; waits for in_ready, presents operands for one edge
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold,
                        output int acc_cyc);
      int n = 0;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      acc_cyc      = cyc + 1;
      exp_q.push_back('{prod: (2*N)'(a) * (2*N)'(b), acc_cyc: acc_cyc, lat: exp_lat(b)});
      @(negedge clk);
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ac, prev_ac;
      logic [2*N-1:0] held;
      logic [N-1:0] pa [3];
      logic [N-1:0] pb [3];
      int n;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_product", 32'(bus.product), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // basic products and operand corners
      issue(8'h0C, 8'h0A, 1'b0, ac);
      chk("busy_after_accept", 32'(bus.busy), 32'd1);
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      drain();
      issue(8'hFF, 8'hFF, 1'b0, ac); drain();
      issue(8'h5A, 8'h00, 1'b0, ac); drain();
      issue(8'h00, 8'hFF, 1'b0, ac); drain();
      issue(8'h01, 8'h80, 1'b0, ac); drain();

      // back-pressure: product held, new operands ignored
      bus.out_ready = 1'b0;
      issue(8'h12, 8'h34, 1'b0, ac);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      held = bus.product;
      chk("bp_value", 32'(held), 32'h03A8);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 8'h99;
         bus.b        = 8'h77;
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_hold_product", 32'(bus.product), 32'(held));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
      issue(8'h99, 8'h77, 1'b0, ac);
      chk("bp_accept_cycle", 32'(bus.busy), 32'd1);
      drain();

      // reset in the middle of an operation
      issue(8'h21, 8'h43, 1'b0, ac);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_product", 32'(bus.product), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(8'h03, 8'h07, 1'b0, ac);
      drain();
      chk("after_rst_product", 32'(bus.product), 32'h0015);

      // back-to-back with in_valid and out_ready held high
      pa = '{8'hA5, 8'h3C, 8'hE7};
      pb = '{8'h5B, 8'hC3, 8'h81};
      prev_ac = 0;
      for (int i = 0; i < 3; i++) begin
         issue(pa[i], pb[i], 1'b1, ac);
         if (i > 0) chk("issue_interval", 32'(ac - prev_ac), 32'(exp_lat(pb[i-1]) + 2));
         prev_ac = ac;
      end
      bus.in_valid = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
